// File: rtl/map_sst_pkg.sv
// map_sst_pkg: shared state encoding and address width for the mapper save-state controller.
package map_sst_pkg;
  localparam int SST_ADDR_BITS = 6;
  typedef enum logic [2:0] {
    IDLE,
    SAVE_ADDR,
    SAVE_DATA,
    LOAD_WAIT,
    LOAD_WR,
    FINISH
  } sst_state_e;
endpackage

// File: rtl/map_sst_ctrl.sv
// map_sst_ctrl: streams mapper save-state registers out to a host (save) or back in from it (load).
module map_sst_ctrl
  import map_sst_pkg::*;
#(
  parameter int SST_REGS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_save,
  input  logic                     start_load,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     sst_enable,
  output logic                     sst_we,
  output logic [SST_ADDR_BITS-1:0] sst_addr,
  output logic [7:0]               sst_data_in,
  input  logic [7:0]               sst_data_out
);
  sst_state_e               state_q;
  logic [SST_ADDR_BITS-1:0] idx_q;
  logic [7:0]               out_data_q;
  logic [7:0]               sst_data_in_q;
  logic                     last;
  assign last = idx_q == SST_ADDR_BITS'(SST_REGS - 1);
  // Abort takes priority over any handshake, so no write or byte is committed on that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      out_data_q    <= '0;
      sst_data_in_q <= '0;
    end else if (abort && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          idx_q   <= '0;
          state_q <= start_save ? SAVE_ADDR : start_load ? LOAD_WAIT : IDLE;
        end
        SAVE_ADDR: begin
          out_data_q <= sst_data_out;
          state_q    <= SAVE_DATA;
        end
        SAVE_DATA: if (out_ready) begin
          idx_q   <= last ? idx_q : idx_q + SST_ADDR_BITS'(1);
          state_q <= last ? FINISH : SAVE_ADDR;
        end
        LOAD_WAIT: if (in_valid) begin
          sst_data_in_q <= in_data;
          state_q       <= LOAD_WR;
        end
        LOAD_WR: begin
          idx_q   <= last ? idx_q : idx_q + SST_ADDR_BITS'(1);
          state_q <= last ? FINISH : LOAD_WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign sst_enable  = state_q != IDLE;
  assign busy        = sst_enable;
  assign done        = state_q == FINISH;
  assign out_valid   = state_q == SAVE_DATA;
  assign in_ready    = state_q == LOAD_WAIT;
  assign sst_we      = state_q == LOAD_WR;
  assign sst_addr    = sst_enable ? idx_q : '0;
  assign out_data    = out_data_q;
  assign sst_data_in = sst_data_in_q;
endmodule

// File: tb/tb_map_sst_ctrl.sv
// tb_map_sst_ctrl: directed checks of save/load streaming, abort, reset and stall behaviour.
module tb_map_sst_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, start_save, start_load, start64, abort, out_ready, in_valid;
  logic [7:0] in_data;
  logic       busy, done, out_valid, in_ready, sst_enable, sst_we;
  logic [7:0] out_data, sst_data_in, sst_data_out;
  logic [5:0] sst_addr;
  logic       b64, d64, v64, r64, e64, w64;
  logic [7:0] o64, di64, do64;
  logic [5:0] a64;
  assign sst_data_out = 8'hA0 + {2'b00, sst_addr};
  assign do64         = 8'hA0 + {2'b00, a64};
  map_sst_ctrl #(.SST_REGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_save(start_save), .start_load(start_load), .abort(abort),
    .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sst_enable(sst_enable),
    .sst_we(sst_we), .sst_addr(sst_addr), .sst_data_in(sst_data_in), .sst_data_out(sst_data_out)
  );
  map_sst_ctrl dut64 (
    .clk(clk), .rst_n(rst_n), .start_save(start64), .start_load(1'b0), .abort(abort),
    .busy(b64), .done(d64), .out_data(o64), .out_valid(v64), .out_ready(out_ready),
    .in_data(in_data), .in_valid(1'b0), .in_ready(r64), .sst_enable(e64),
    .sst_we(w64), .sst_addr(a64), .sst_data_in(di64), .sst_data_out(do64)
  );
  int checks = 0, errors = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, last_hs = 0, ov_cnt = 0, stall_err = 0;
  logic [7:0] sq[$];
  logic [7:0] q64[$];
  logic [5:0] we_a[$];
  logic [7:0] we_d[$];
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic [7:0] ltbl[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  always @(posedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      sq.push_back(out_data);
      last_hs = cyc;
    end
    if (out_valid) ov_cnt++;
    if (sst_we) begin
      we_a.push_back(sst_addr);
      we_d.push_back(sst_data_in);
    end
    if (v64 && out_ready) q64.push_back(o64);
    if (prev_v && !prev_r && !(v64 && o64 == prev_d)) stall_err++;
    prev_v = v64;
    prev_r = out_ready;
    prev_d = o64;
    cyc++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_mon();
    sq.delete();
    we_a.delete();
    we_d.delete();
    done_cnt = 0;
    ov_cnt = 0;
  endtask
  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_data = ltbl[i];
      in_valid = 1'b1;
      for (int k = 0; k < 20 && !in_ready; k++) tick();
      checks++;
      if (!in_ready) begin
        errors++;
        $display("FAIL load_ready[%0d]: in_ready=%b required 1", i, in_ready);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (sst_we !== 1'b1 || sst_addr !== 6'(i) || sst_data_in !== ltbl[i]) begin
        errors++;
        $display("FAIL load_wr[%0d]: we=%b addr=%0d data=%h required we=1 addr=%0d data=%h",
                 i, sst_we, sst_addr, sst_data_in, i, ltbl[i]);
      end
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0; start_save = 0; start_load = 0; start64 = 0; abort = 0;
    out_ready = 0; in_valid = 0; in_data = 8'h00;
    tick(); tick();
    checks++;
    if ({busy, done, out_valid, in_ready, sst_enable, sst_we} !== 6'b0 || sst_addr !== 6'd0 ||
        out_data !== 8'h00 || sst_data_in !== 8'h00) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b ov=%b ir=%b en=%b we=%b addr=%0d od=%h di=%h required all 0",
               busy, done, out_valid, in_ready, sst_enable, sst_we, sst_addr, out_data, sst_data_in);
    end
    rst_n = 1'b1;
    tick();
  endtask
  task automatic check_save_bytes(input string name);
    checks++;
    if (sq.size() != 4) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes required 4", name, sq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sq[i] !== 8'hA0 + 8'(i)) begin
          errors++;
          $display("FAIL %s_byte[%0d]: got %h required %h", name, i, sq[i], 8'hA0 + 8'(i));
        end
      end
    end
  endtask
  task automatic test_save();
    bit ok;
    clear_mon();
    out_ready = 1'b1;
    start_save = 1'b1; tick(); start_save = 1'b0;
    checks++;
    if ({busy, sst_enable, out_valid, sst_we} !== 4'b1100 || sst_addr !== 6'd0) begin
      errors++;
      $display("FAIL save_addr0: busy=%b en=%b ov=%b we=%b addr=%0d required 1,1,0,0,0",
               busy, sst_enable, out_valid, sst_we, sst_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      errors++;
      $display("FAIL save_data0: ov=%b data=%h required 1 a0", out_valid, out_data);
    end
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL save_done: done=%b required 1 within bound", done);
    end
    tick();
    check_save_bytes("save");
    checks++;
    if (done_cyc != last_hs + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL save_done_timing: done at %0d (count %0d) required %0d (count 1)",
               done_cyc, done_cnt, last_hs + 1);
    end
    checks++;
    if (we_a.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL save_end: we_pulses=%0d busy=%b done=%b required 0 0 0", we_a.size(), busy, done);
    end
  endtask
  task automatic test_load();
    bit ok;
    clear_mon();
    start_load = 1'b1; tick(); start_load = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sst_addr !== 6'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_start: ir=%b ov=%b addr=%0d busy=%b required 1 0 0 1",
               in_ready, out_valid, sst_addr, busy);
    end
    feed(4);
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL load_done: done=%b required 1 within bound", done);
    end
    tick();
    checks++;
    if (we_a.size() != 4) begin
      errors++;
      $display("FAIL load_we_count: got %0d required 4", we_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (we_a[i] !== 6'(i) || we_d[i] !== ltbl[i]) begin
          errors++;
          $display("FAIL load_we[%0d]: addr=%0d data=%h required %0d %h", i, we_a[i], we_d[i], i, ltbl[i]);
        end
      end
    end
    checks++;
    if (ov_cnt != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL load_misc: out_valid_cycles=%0d done_count=%0d required 0 1", ov_cnt, done_cnt);
    end
  endtask
  task automatic test_both_start();
    bit ok;
    clear_mon();
    out_ready = 1'b1;
    start_save = 1'b1; start_load = 1'b1; tick(); start_save = 1'b0; start_load = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_start: busy=%b ir=%b required 1 0", busy, in_ready);
    end
    start_load = 1'b1; tick(); start_load = 1'b0;
    wait_done(ok);
    tick();
    checks++;
    if (!ok || we_a.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL both_end: done_seen=%b we_pulses=%0d busy=%b required 1 0 0", ok, we_a.size(), busy);
    end
    check_save_bytes("both");
  endtask
  task automatic test_back_to_back();
    bit ok;
    clear_mon();
    out_ready = 1'b1;
    start_save = 1'b1; tick(); start_save = 1'b0;
    wait_done(ok);
    tick();
    start_load = 1'b1; tick(); start_load = 1'b0;
    checks++;
    if (!ok || in_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: done_seen=%b ir=%b busy=%b required 1 1 1", ok, in_ready, busy);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_abort: busy=%b ir=%b required 0 0", busy, in_ready);
    end
  endtask
  task automatic test_abort();
    bit ok;
    clear_mon();
    start_load = 1'b1; tick(); start_load = 1'b0;
    feed(2);
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    in_data = 8'h99; in_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || sst_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ir=%b we=%b done=%b required 0 0 0 0", busy, in_ready, sst_we, done);
    end
    repeat (5) tick();
    checks++;
    if (we_a.size() != 2 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_counts: we_pulses=%0d done_count=%0d required 2 0", we_a.size(), done_cnt);
    end
    clear_mon();
    out_ready = 1'b1;
    start_save = 1'b1; tick(); start_save = 1'b0;
    wait_done(ok);
    tick();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL abort_resave: done=%b required 1 within bound", done);
    end
    check_save_bytes("resave");
  endtask
  task automatic test_reset_mid();
    clear_mon();
    out_ready = 1'b0;
    start_save = 1'b1; tick(); start_save = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      errors++;
      $display("FAIL rstmid_pre: ov=%b data=%h required 1 a0", out_valid, out_data);
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++;
    if ({busy, done, out_valid, in_ready, sst_enable, sst_we} !== 6'b0 || sst_addr !== 6'd0 ||
        out_data !== 8'h00 || sst_data_in !== 8'h00) begin
      errors++;
      $display("FAIL rstmid: busy=%b done=%b ov=%b ir=%b en=%b we=%b addr=%0d od=%h di=%h required all 0",
               busy, done, out_valid, in_ready, sst_enable, sst_we, sst_addr, out_data, sst_data_in);
    end
    out_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (done_cnt != 0 || we_a.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: done_count=%0d we_pulses=%0d busy=%b required 0 0 0",
               done_cnt, we_a.size(), busy);
    end
  endtask
  task automatic test_stall64();
    int run = 0, bad = 0;
    bit ok = 1'b0;
    q64.delete();
    stall_err = 0;
    start64 = 1'b1; tick(); start64 = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (d64) begin
        ok = 1'b1;
        break;
      end
      out_ready = (run >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
      run = out_ready ? 0 : run + 1;
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (!ok || q64.size() != 64) begin
      errors++;
      $display("FAIL stall_count: done_seen=%b bytes=%0d required 1 64", ok, q64.size());
    end
    for (int i = 0; i < q64.size() && i < 64; i++) if (q64[i] !== 8'hA0 + 8'(i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_bytes: %0d wrong bytes required 0", bad);
    end
    checks++;
    if (stall_err != 0 || b64 !== 1'b0) begin
      errors++;
      $display("FAIL stall_stable: unstable_stalls=%0d busy=%b required 0 0", stall_err, b64);
    end
  endtask
  initial begin
    test_reset();
    test_save();
    test_load();
    test_both_start();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_stall64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/map_sst_ctrl.md
MAP_SST_CTRL -- requirements
Module: map_sst_ctrl

Interface
REQ-001 SHALL have parameter SST_REGS, default 64, number of mapper save-state registers transferred per operation (1..64).
REQ-002 SHALL have port clk  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports start_save / start_load  input  1 each  single-cycle operation requests.
REQ-005 SHALL have port abort  input  1  terminates any operation.
REQ-006 SHALL have ports busy / done  output  1 each  operation in progress / one-cycle completion pulse.
REQ-007 SHALL have ports out_data  output  8, out_valid  output  1, out_ready  input  1  save byte stream to host.
REQ-008 SHALL have ports in_data  input  8, in_valid  input  1, in_ready  output  1  load byte stream from host.
REQ-009 SHALL have ports sst_enable  output  1, sst_we  output  1, sst_addr  output  6, sst_data_in  output  8, sst_data_out  input  8  mapper save-state side of the map bus.

Function
REQ-010 SHALL implement states IDLE, SAVE_ADDR, SAVE_DATA, LOAD_WAIT, LOAD_WR, FINISH.
REQ-011 SHALL, in IDLE, go to SAVE_ADDR on start_save, else to LOAD_WAIT on start_load; start_save wins when both are asserted.
REQ-012 SHALL ignore start_save/start_load outside IDLE.
REQ-013 SHALL hold sst_enable=1 in every state except IDLE; busy SHALL equal sst_enable.
REQ-014 SHALL keep a 6-bit index, cleared on leaving IDLE, and drive sst_addr from it in all non-IDLE states.
REQ-015 SHALL, in SAVE_ADDR, present sst_addr=index for one cycle (mapper read latency is 1 cycle), then enter SAVE_DATA and register sst_data_out into out_data.
REQ-016 SHALL assert out_valid throughout SAVE_DATA and hold out_data stable until out_valid&&out_ready.
REQ-017 SHALL, on handshake in SAVE_DATA, go to FINISH if index==SST_REGS-1, else increment index and return to SAVE_ADDR.
REQ-018 SHALL assert in_ready only in LOAD_WAIT; on in_valid&&in_ready, register in_data to sst_data_in and enter LOAD_WR.
REQ-019 SHALL assert sst_we for exactly the single LOAD_WR cycle with sst_addr=index, then go to FINISH if index==SST_REGS-1, else increment index and return to LOAD_WAIT.
REQ-020 SHALL never assert sst_we during save and never assert out_valid during load.
REQ-021 SHALL, in FINISH, assert done for one cycle with sst_enable=1, then return to IDLE.
REQ-022 SHALL, on abort in any non-IDLE state, return to IDLE next cycle without done, without a pending sst_we, and drop out_valid/in_ready; abort wins over a same-cycle handshake.
REQ-023 SHALL accept a new start request on the cycle immediately after FINISH (in IDLE).

Reset
REQ-024 SHALL, while rst_n=0 at a clk edge, enter IDLE with busy=0, done=0, out_valid=0, in_ready=0, sst_enable=0, sst_we=0, sst_addr=0, sst_data_in=0, out_data=0, index=0.
REQ-025 SHALL treat reset mid-operation like abort: no done, no further sst_we.

Structure
REQ-026 SHALL place the state enum and constant SST_ADDR_BITS=6 in shared package map_sst_pkg.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 Save, SST_REGS=4, mapper model returns 8'hA0+addr, out_ready=1 -> bytes A0,A1,A2,A3 in order, done one cycle after the last handshake, no sst_we asserted.
REQ-029 Load, SST_REGS=4, in_data 11,22,33,44 -> four single-cycle sst_we pulses at addr 0..3 with those data, then done.
REQ-030 Save with out_ready toggled pseudo-randomly (stalls up to 5 cycles) -> out_data stable while stalled, 64 correct bytes, no duplicates or drops.
REQ-031 start_save and start_load in the same cycle -> save operation runs; start_load during busy ignored.
REQ-032 abort during load after 2 bytes -> sst_we count 2, busy low next cycle, no done; following start_save completes normally.
REQ-033 rst_n=0 during SAVE_DATA -> all outputs at reset values next cycle.
